uart_tx_frame_scheduler: RTL and testbench
==========================================

Name: uart_tx_frame_scheduler

Overview:
Weighted round-robin scheduler that shares the single 40-bit UART TX frame FIFO write port between two requesters: the control/command path (40-bit frames) and the bulk communication data path (32-bit payloads, header-prefixed here).
It sits in the Logic_Clock domain between the requesters and the TX FIFO write side. It honours the FIFO almost-full flag and bounds each source's consecutive grants so neither path starves.
It also keeps per-source frame counters for diagnostics.

Parameters:
CTRL_BURST, 2, max consecutive control frames granted while data is pending (1..15)
DATA_BURST, 8, max consecutive data frames granted while control is pending (1..15)
DATA_HEADER, 8'hD0, header byte placed in bits [39:32] of every data frame

Ports:
Clock  in  1  Logic clock; all logic rising-edge
Reset_N  in  1  asynchronous active-low reset
Ctrl_Valid  in  1  control frame available
Ctrl_Data  in  40  control frame
Ctrl_Ready  out  1  control frame consumed this cycle (combinational)
Data_Valid  in  1  data payload available
Data_Frame  in  32  data payload
Data_Ready  out  1  data payload consumed this cycle (combinational)
TX_Fifo_AFull  in  1  TX FIFO almost-full (threshold leaves at least 2 free entries)
TX_Fifo_WE  out  1  registered FIFO write strobe
TX_Fifo_Data  out  40  registered FIFO write data
Owner  out  1  current owner: 0 = control, 1 = data
Ctrl_Count  out  16  control frames written, wraps at 16'hFFFF->0
Data_Count  out  16  data frames written, wraps

Behaviour:
- Clock and reset: one clock (Clock); Reset_N asynchronous assert, active-low. Release is synchronous to Clock and handled upstream.
- Reset values: TX_Fifo_WE=0, TX_Fifo_Data=0, Owner=0, both burst counters=0, Ctrl_Count=0, Data_Count=0. Ctrl_Ready and Data_Ready are 0 while Reset_N=0.
- Grant eligibility: a grant happens in cycle n only if TX_Fifo_AFull=0 and at least one Valid is high. At most one grant per cycle; the two Ready signals are mutually exclusive.
- Grant selection within one cycle, in priority order:
  - Owner's Valid high and burst counter < owner's limit → grant owner.
  - Owner's Valid high, limit reached, other Valid low → grant owner; counter saturates at the limit.
  - Owner's Valid high, limit reached, other Valid high → grant other; Owner toggles; counter := 1.
  - Owner's Valid low, other Valid high → grant other; Owner toggles; counter := 1.
  - Owner's Valid low, other Valid low → no grant; Owner and counter hold.
- Counter on owner grant: a grant to the current owner increments the burst counter.
- Burst counter reset: the counter clears to 0 on any cycle with both Valids low. Owner is unchanged in that case.
- Ready timing: Ready is high in the cycle the grant is issued. The requester treats Valid && Ready as a consumed frame and may present the next frame in the following cycle.
- Write output: the granted frame appears on TX_Fifo_Data with TX_Fifo_WE=1 in cycle n+1 (latency 1).
  - Control frame: Ctrl_Data unchanged.
  - Data frame: {DATA_HEADER, Data_Frame}.
  - In cycles with no grant, TX_Fifo_WE=0 and TX_Fifo_Data holds its last value.
- Back-pressure: while TX_Fifo_AFull=1, both Ready=0 and nothing is written. Owner and counters hold.
  - AFull rising in the same cycle as a grant request blocks that grant.
  - A write already registered in the previous cycle still completes; the almost-full margin covers it.
- Statistics: Ctrl_Count or Data_Count increments in the cycle TX_Fifo_WE=1 for that source's frame; each wraps modulo 2^16.
- Reset mid-operation: a pending registered write is dropped (TX_Fifo_WE forced 0 asynchronously); counters clear.
- Valid deassertion: Valid may drop without a grant; no state is kept for ungranted frames.

Test Plan:
1. Control-only stream: Ctrl_Valid=1 with Ctrl_Data=40'h01_0000_0001, incrementing, 5 frames, Data_Valid=0 → 5 consecutive writes of those values starting 1 cycle after the first Ready; Ctrl_Count=5; Owner stays 0.
2. Data-only stream: Data_Frame=32'hA5A5_0000..0003, Data_Valid=1 → writes 40'hD0_A5A5_0000..0003 back-to-back; Owner=1 from the first grant; Data_Count=4.
3. Both sources valid continuously, CTRL_BURST=2, DATA_BURST=8 → repeating grant pattern C,C,D×8,C,C,D×8…. Over 40 cycles: Ctrl_Count=8, Data_Count=32; Ready signals never both high.
4. TX_Fifo_AFull=1 for 6 cycles mid data burst → Ready=0 for those 6 cycles. Exactly one trailing write occurs (from the grant before AFull). The burst resumes with the unchanged counter after AFull drops.
5. Owner's Valid drops while the other is valid → the other is granted in that same cycle; Owner toggles; the next handover occurs only after the other's full burst limit.
6. Reset_N pulsed low while TX_Fifo_WE=1 → TX_Fifo_WE goes 0 immediately; after release, Owner=0, Ctrl_Count and Data_Count = 0, and normal arbitration restarts with control ownership.

Source files
------------

// File: rtl/uart_tx_frame_scheduler.sv
// Weighted round-robin arbiter sharing the 40-bit UART TX FIFO write port
// between the control path and the header-prefixed bulk data path.
//
// state    | meaning
// ---------+-------------------------------------------------
// OWN_CTRL | control path owns the port, burst_q counts its grants
// OWN_DATA | data path owns the port, burst_q counts its grants
module uart_tx_frame_scheduler #(
  parameter int unsigned CTRL_BURST  = 2,
  parameter int unsigned DATA_BURST  = 8,
  parameter logic [7:0]  DATA_HEADER = 8'hD0
) (
  input  logic        Clock,
  input  logic        Reset_N,
  input  logic        Ctrl_Valid,
  input  logic [39:0] Ctrl_Data,
  output logic        Ctrl_Ready,
  input  logic        Data_Valid,
  input  logic [31:0] Data_Frame,
  output logic        Data_Ready,
  input  logic        TX_Fifo_AFull,
  output logic        TX_Fifo_WE,
  output logic [39:0] TX_Fifo_Data,
  output logic        Owner,
  output logic [15:0] Ctrl_Count,
  output logic [15:0] Data_Count
);

  typedef enum logic {OWN_CTRL = 1'b0, OWN_DATA = 1'b1} owner_t;

  localparam logic [3:0] CTRL_LIM = 4'(CTRL_BURST);
  localparam logic [3:0] DATA_LIM = 4'(DATA_BURST);

  owner_t      owner_q, owner_d;
  logic [3:0]  burst_q, burst_d;
  logic [3:0]  limit;
  logic        own_valid, oth_valid;
  logic        grant_own, grant_oth;
  logic        grant_ctrl, grant_data;
  logic        we_q;
  logic [39:0] data_q;
  logic [15:0] ctrl_cnt_q, data_cnt_q;

  always_comb begin
    owner_d   = owner_q;
    burst_d   = burst_q;
    grant_own = 1'b0;
    grant_oth = 1'b0;
    own_valid = (owner_q == OWN_CTRL) ? Ctrl_Valid : Data_Valid;
    oth_valid = (owner_q == OWN_CTRL) ? Data_Valid : Ctrl_Valid;
    limit     = (owner_q == OWN_CTRL) ? CTRL_LIM : DATA_LIM;
    // almost-full freezes owner and burst counter entirely
    if (!TX_Fifo_AFull) begin
      if (own_valid && (burst_q < limit)) begin
        grant_own = 1'b1;
        burst_d   = burst_q + 4'd1;
      end else if (own_valid && !oth_valid) begin
        grant_own = 1'b1;
        burst_d   = limit;
      end else if (oth_valid) begin
        grant_oth = 1'b1;
        owner_d   = (owner_q == OWN_CTRL) ? OWN_DATA : OWN_CTRL;
        burst_d   = 4'd1;
      end else begin
        burst_d   = 4'd0;
      end
    end
    grant_ctrl = (grant_own && (owner_q == OWN_CTRL)) || (grant_oth && (owner_q == OWN_DATA));
    grant_data = (grant_own && (owner_q == OWN_DATA)) || (grant_oth && (owner_q == OWN_CTRL));
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      owner_q    <= OWN_CTRL;
      burst_q    <= 4'd0;
      we_q       <= 1'b0;
      data_q     <= 40'd0;
      ctrl_cnt_q <= 16'd0;
      data_cnt_q <= 16'd0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
      we_q    <= grant_ctrl || grant_data;
      if (grant_ctrl) begin
        data_q     <= Ctrl_Data;
        ctrl_cnt_q <= ctrl_cnt_q + 16'd1;
      end else if (grant_data) begin
        data_q     <= {DATA_HEADER, Data_Frame};
        data_cnt_q <= data_cnt_q + 16'd1;
      end
    end
  end

  assign Ctrl_Ready   = grant_ctrl && Reset_N;
  assign Data_Ready   = grant_data && Reset_N;
  assign TX_Fifo_WE   = we_q;
  assign TX_Fifo_Data = data_q;
  assign Owner        = owner_q;
  assign Ctrl_Count   = ctrl_cnt_q;
  assign Data_Count   = data_cnt_q;

endmodule

// File: tb/tb_uart_tx_frame_scheduler.sv
// Self-checking bench for uart_tx_frame_scheduler: a negedge monitor keeps a
// scoreboard of granted frames and a grant log that each scenario task checks.
module tb_uart_tx_frame_scheduler;

  logic        Clock = 1'b0;
  logic        Reset_N;
  logic        Ctrl_Valid;
  logic [39:0] Ctrl_Data;
  logic        Ctrl_Ready;
  logic        Data_Valid;
  logic [31:0] Data_Frame;
  logic        Data_Ready;
  logic        TX_Fifo_AFull;
  logic        TX_Fifo_WE;
  logic [39:0] TX_Fifo_Data;
  logic        Owner;
  logic [15:0] Ctrl_Count;
  logic [15:0] Data_Count;

  int n_cmp = 0;
  int n_err = 0;
  int wr_total = 0;
  int ctrl_left = 0;
  int data_left = 0;
  logic [39:0] sb[$];
  byte         glog[$];

  uart_tx_frame_scheduler #(.CTRL_BURST(2), .DATA_BURST(8), .DATA_HEADER(8'hD0)) dut (
    .Clock(Clock), .Reset_N(Reset_N),
    .Ctrl_Valid(Ctrl_Valid), .Ctrl_Data(Ctrl_Data), .Ctrl_Ready(Ctrl_Ready),
    .Data_Valid(Data_Valid), .Data_Frame(Data_Frame), .Data_Ready(Data_Ready),
    .TX_Fifo_AFull(TX_Fifo_AFull), .TX_Fifo_WE(TX_Fifo_WE), .TX_Fifo_Data(TX_Fifo_Data),
    .Owner(Owner), .Ctrl_Count(Ctrl_Count), .Data_Count(Data_Count)
  );

  always #5 Clock = ~Clock;

  // scoreboard monitor: pop/compare writes, then push this cycle's grant
  always @(negedge Clock) begin
    if (Reset_N) begin
      if (TX_Fifo_WE) begin
        wr_total++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_underflow: write of %h with no granted frame outstanding", TX_Fifo_Data);
        end else begin
          logic [39:0] exp_v;
          exp_v = sb.pop_front();
          if (TX_Fifo_Data !== exp_v) begin
            n_err++;
            $display("FAIL fifo_data: got %h expected %h", TX_Fifo_Data, exp_v);
          end
        end
      end
      n_cmp++;
      if ((Ctrl_Ready && Data_Ready) || (Ctrl_Ready && !Ctrl_Valid) || (Data_Ready && !Data_Valid)
          || (TX_Fifo_AFull && (Ctrl_Ready || Data_Ready))) begin
        n_err++;
        $display("FAIL ready_rules: ctrl_ready=%b data_ready=%b ctrl_valid=%b data_valid=%b afull=%b required no illegal grant",
                 Ctrl_Ready, Data_Ready, Ctrl_Valid, Data_Valid, TX_Fifo_AFull);
      end
      if (Ctrl_Ready) begin
        sb.push_back(Ctrl_Data);
        glog.push_back(8'h43);
      end else if (Data_Ready) begin
        sb.push_back({8'hD0, Data_Frame});
        glog.push_back(8'h44);
      end else begin
        glog.push_back(8'h2D);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic string log_str();
    string s = "";
    foreach (glog[i]) s = {s, $sformatf("%c", glog[i])};
    return s;
  endfunction

  task automatic run_cycles(input int n);
    logic cr, dr;
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      cr = Ctrl_Ready;
      dr = Data_Ready;
      @(posedge Clock);
      #1;
      if (cr) begin ctrl_left--; Ctrl_Data = Ctrl_Data + 40'd1; end
      if (dr) begin data_left--; Data_Frame = Data_Frame + 32'd1; end
      Ctrl_Valid = (ctrl_left > 0);
      Data_Valid = (data_left > 0);
    end
  endtask

  task automatic apply_reset();
    Reset_N = 1'b0;
    ctrl_left = 0; data_left = 0;
    Ctrl_Valid = 1'b0; Data_Valid = 1'b0; TX_Fifo_AFull = 1'b0;
    sb.delete();
    repeat (2) @(posedge Clock);
    #3 Reset_N = 1'b1;
    @(posedge Clock);
    #1 glog.delete();
  endtask

  task automatic quiesce(input string name);
    ctrl_left = 0; data_left = 0;
    Ctrl_Valid = 1'b0; Data_Valid = 1'b0; TX_Fifo_AFull = 1'b0;
    run_cycles(3);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d frames never written, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    Reset_N = 1'b0;
    Ctrl_Valid = 1'b1; Data_Valid = 1'b1; TX_Fifo_AFull = 1'b0;
    Ctrl_Data = 40'h12_3456_789A; Data_Frame = 32'hDEAD_BEEF;
    #12;
    n_cmp++; if (TX_Fifo_WE !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b expected 0", TX_Fifo_WE); end
    n_cmp++; if (TX_Fifo_Data !== 40'd0) begin n_err++; $display("FAIL rst_data: got %h expected 0", TX_Fifo_Data); end
    n_cmp++; if (Owner !== 1'b0) begin n_err++; $display("FAIL rst_owner: got %b expected 0", Owner); end
    n_cmp++; if (Ctrl_Count !== 16'd0 || Data_Count !== 16'd0) begin
      n_err++; $display("FAIL rst_counts: got %0d/%0d expected 0/0", Ctrl_Count, Data_Count); end
    n_cmp++; if (Ctrl_Ready !== 1'b0 || Data_Ready !== 1'b0) begin
      n_err++; $display("FAIL rst_ready: got %b/%b expected 0/0", Ctrl_Ready, Data_Ready); end
  endtask

  task automatic test_ctrl_only();
    apply_reset();
    Ctrl_Data = 40'h01_0000_0001; ctrl_left = 5; Ctrl_Valid = 1'b1;
    run_cycles(7);
    n_cmp++; if (log_str() != "CCCCC--") begin n_err++; $display("FAIL ctrl_pattern: got %s expected CCCCC--", log_str()); end
    n_cmp++; if (Ctrl_Count !== 16'd5 || Data_Count !== 16'd0) begin
      n_err++; $display("FAIL ctrl_counts: got %0d/%0d expected 5/0", Ctrl_Count, Data_Count); end
    n_cmp++; if (Owner !== 1'b0) begin n_err++; $display("FAIL ctrl_owner: got %b expected 0", Owner); end
    n_cmp++; if (TX_Fifo_WE !== 1'b0 || TX_Fifo_Data !== 40'h01_0000_0005) begin
      n_err++; $display("FAIL ctrl_hold: got we=%b data=%h expected we=0 data=0100000005", TX_Fifo_WE, TX_Fifo_Data); end
    quiesce("ctrl");
  endtask

  task automatic test_data_only();
    apply_reset();
    Data_Frame = 32'hA5A5_0000; data_left = 4; Data_Valid = 1'b1;
    run_cycles(6);
    n_cmp++; if (log_str() != "DDDD--") begin n_err++; $display("FAIL data_pattern: got %s expected DDDD--", log_str()); end
    n_cmp++; if (Data_Count !== 16'd4 || Ctrl_Count !== 16'd0) begin
      n_err++; $display("FAIL data_counts: got %0d/%0d expected 0/4", Ctrl_Count, Data_Count); end
    n_cmp++; if (Owner !== 1'b1) begin n_err++; $display("FAIL data_owner: got %b expected 1", Owner); end
    n_cmp++; if (TX_Fifo_Data !== 40'hD0_A5A5_0003) begin
      n_err++; $display("FAIL data_last: got %h expected D0A5A50003", TX_Fifo_Data); end
    quiesce("data");
  endtask

  task automatic test_weighted_rr();
    string exp_s = "";
    apply_reset();
    Ctrl_Data = 40'hC0_0000_0000; Data_Frame = 32'h0000_1000;
    ctrl_left = 1000; data_left = 1000; Ctrl_Valid = 1'b1; Data_Valid = 1'b1;
    run_cycles(40);
    for (int i = 0; i < 40; i++) exp_s = {exp_s, ((i % 10) < 2) ? "C" : "D"};
    n_cmp++; if (log_str() != exp_s) begin n_err++; $display("FAIL wrr_pattern: got %s expected %s", log_str(), exp_s); end
    n_cmp++; if (Ctrl_Count !== 16'd8 || Data_Count !== 16'd32) begin
      n_err++; $display("FAIL wrr_counts: got %0d/%0d expected 8/32", Ctrl_Count, Data_Count); end
    quiesce("wrr");
  endtask

  task automatic test_afull();
    int w0;
    apply_reset();
    Ctrl_Data = 40'h0C_0000_0000; Data_Frame = 32'h0000_2000;
    ctrl_left = 1000; data_left = 1000; Ctrl_Valid = 1'b1; Data_Valid = 1'b1;
    run_cycles(5);
    TX_Fifo_AFull = 1'b1;
    w0 = wr_total;
    run_cycles(6);
    n_cmp++; if (wr_total - w0 != 1) begin n_err++; $display("FAIL afull_trailing: got %0d writes expected 1", wr_total - w0); end
    n_cmp++; if (Ctrl_Count !== 16'd2 || Data_Count !== 16'd3 || Owner !== 1'b1) begin
      n_err++; $display("FAIL afull_hold: got %0d/%0d owner=%b expected 2/3 owner=1", Ctrl_Count, Data_Count, Owner); end
    TX_Fifo_AFull = 1'b0;
    run_cycles(7);
    n_cmp++; if (log_str() != "CCDDD------DDDDDCC") begin
      n_err++; $display("FAIL afull_pattern: got %s expected CCDDD------DDDDDCC", log_str()); end
    quiesce("afull");
  endtask

  task automatic test_handover();
    apply_reset();
    Ctrl_Data = 40'h0A_0000_0000; Data_Frame = 32'h0000_3000;
    ctrl_left = 1; data_left = 1000; Ctrl_Valid = 1'b1; Data_Valid = 1'b1;
    run_cycles(2);
    n_cmp++; if (Owner !== 1'b1) begin n_err++; $display("FAIL handover_owner: got %b expected 1", Owner); end
    ctrl_left = 100; Ctrl_Valid = 1'b1;
    run_cycles(10);
    n_cmp++; if (log_str() != "CDDDDDDDDCCD") begin
      n_err++; $display("FAIL handover_pattern: got %s expected CDDDDDDDDCCD", log_str()); end
    quiesce("handover");
  endtask

  task automatic test_reset_midop();
    apply_reset();
    Data_Frame = 32'h0000_4000; data_left = 100; Data_Valid = 1'b1;
    run_cycles(3);
    n_cmp++; if (TX_Fifo_WE !== 1'b1 || Data_Count !== 16'd3) begin
      n_err++; $display("FAIL midrst_pre: got we=%b count=%0d expected we=1 count=3", TX_Fifo_WE, Data_Count); end
    Ctrl_Data = 40'h0B_0000_0000; ctrl_left = 100; Ctrl_Valid = 1'b1;
    Reset_N = 1'b0;
    #1;
    n_cmp++; if (TX_Fifo_WE !== 1'b0) begin n_err++; $display("FAIL midrst_we: got %b expected 0", TX_Fifo_WE); end
    n_cmp++; if (Owner !== 1'b0 || Ctrl_Count !== 16'd0 || Data_Count !== 16'd0) begin
      n_err++; $display("FAIL midrst_state: got owner=%b %0d/%0d expected owner=0 0/0", Owner, Ctrl_Count, Data_Count); end
    n_cmp++; if (Ctrl_Ready !== 1'b0 || Data_Ready !== 1'b0) begin
      n_err++; $display("FAIL midrst_ready: got %b/%b expected 0/0", Ctrl_Ready, Data_Ready); end
    sb.delete();
    @(posedge Clock);
    #3 Reset_N = 1'b1;
    glog.delete();
    run_cycles(3);
    n_cmp++; if (log_str() != "CCD") begin n_err++; $display("FAIL midrst_restart: got %s expected CCD", log_str()); end
    n_cmp++; if (Ctrl_Count !== 16'd2 || Data_Count !== 16'd1) begin
      n_err++; $display("FAIL midrst_counts: got %0d/%0d expected 2/1", Ctrl_Count, Data_Count); end
    quiesce("midrst");
  endtask

  initial begin
    test_reset();
    test_ctrl_only();
    test_data_only();
    test_weighted_rr();
    test_afull();
    test_handover();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
